// File: rtl/can_pkg.sv
// can_pkg: states, CRC polynomial, field lengths and byte-count helper for the CAN receive sequencer
package can_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_ERROR
  } can_state_e;
  localparam int CAN_CRC_BITS = 15;
  localparam logic [14:0] CAN_CRC_POLY = 15'h4599;
  localparam int ID_BASE = 11;
  localparam int ID_EXT = 18;
  localparam int DLC_W = 4;
  localparam int STUFF_RUN = 5;
  localparam int EOF_BITS = 7;
  localparam int IDLE_BITS = 11;
  function automatic logic [3:0] data_bytes(input logic [3:0] dlc, input logic rtr);
    return rtr ? 4'd0 : (dlc[3] ? 4'd8 : dlc);
  endfunction
endpackage

// File: rtl/can_crc15_unit.sv
// can_crc15_unit: CAN CRC-15 remainder register (clr over shift); zero flags a remainder of 0 once din is shifted in
module can_crc15_unit
  import can_pkg::*;
#(
  parameter int CRC_BITS = CAN_CRC_BITS,
  parameter logic [CRC_BITS-1:0] CRC_POLY = CAN_CRC_POLY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic shift,
  input  logic din,
  output logic zero
);
  logic [CRC_BITS-1:0] rem_q, rem_d, rem_n;
  always_comb begin
    rem_n = {rem_q[CRC_BITS-2:0], din} ^ (rem_q[CRC_BITS-1] ? CRC_POLY : '0);
    rem_d = clr ? '0 : (shift ? rem_n : rem_q);
  end
  // looks one bit ahead so the check lands on the strobe of the last CRC bit
  assign zero = rem_n == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rem_q <= '0;
    else rem_q <= rem_d;
endmodule

// File: rtl/can_rx_frame_ctrl.sv
// can_rx_frame_ctrl: CAN 2.0 receive sequencer (destuff, field tracking, CRC-15 check, frame/error report); CAN_RX_EXT_ID_EN enables 29-bit IDs
module can_rx_frame_ctrl
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_en,
  input  logic        rx_bit,
  output logic        busy,
  output logic        frame_valid,
  output logic [28:0] frame_id,
  output logic        frame_ext,
  output logic        frame_rtr,
  output logic [3:0]  frame_dlc,
  output logic [63:0] frame_data,
  output logic        crc_err,
  output logic        stuff_err,
  output logic        form_err
);
  can_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [28:0] id_q, id_d, frame_id_q, frame_id_d;
  logic rtr_q, rtr_d, ext_q, ext_d, frame_rtr_q, frame_rtr_d, frame_ext_q, frame_ext_d;
  logic [3:0] dlc_q, dlc_d, frame_dlc_q, frame_dlc_d;
  logic [63:0] data_q, data_d, frame_data_q, frame_data_d;
  logic run_val_q, run_val_d;
  logic [2:0] run_len_q, run_len_d;
  logic frame_valid_q, frame_valid_d, crc_err_q, crc_err_d, stuff_err_q, stuff_err_d, form_err_q, form_err_d;
  logic stuff_due, destuff, crc_zero, crc_clr, crc_shift;
  logic [3:0] nb_ctrl, nb_data;
  assign nb_ctrl = data_bytes({dlc_q[2:0], rx_bit}, rtr_q);
  assign nb_data = data_bytes(dlc_q, rtr_q);
  can_crc15_unit #(.CRC_BITS(CAN_CRC_BITS), .CRC_POLY(CAN_CRC_POLY)) u_crc (
    .clk(clk), .rst_n(rst_n), .clr(crc_clr), .shift(crc_shift), .din(rx_bit), .zero(crc_zero)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    id_d = id_q;
    rtr_d = rtr_q;
    ext_d = ext_q;
    dlc_d = dlc_q;
    data_d = data_q;
    run_val_d = run_val_q;
    run_len_d = run_len_q;
    crc_clr = 1'b0;
    crc_shift = 1'b0;
    frame_valid_d = 1'b0;
    crc_err_d = 1'b0;
    stuff_err_d = 1'b0;
    form_err_d = 1'b0;
    frame_id_d = frame_id_q;
    frame_ext_d = frame_ext_q;
    frame_rtr_d = frame_rtr_q;
    frame_dlc_d = frame_dlc_q;
    frame_data_d = frame_data_q;
    stuff_due = run_len_q == 3'(STUFF_RUN);
    // a stuff bit may still follow the last CRC bit, so CRC_DEL destuffs when one is due
    destuff = state_q inside {S_ARB, S_CTRL, S_DATA, S_CRC} || (state_q == S_CRC_DEL && stuff_due);
    if (bit_en) begin
      if (destuff && stuff_due) begin
        if (rx_bit == run_val_q) begin
          stuff_err_d = 1'b1;
          state_d = S_ERROR;
          cnt_d = '0;
        end else begin
          run_val_d = rx_bit;
          run_len_d = 3'd1;
        end
      end else begin
        cnt_d = cnt_q + 6'd1;
        if (destuff) begin
          run_val_d = rx_bit;
          run_len_d = (rx_bit == run_val_q) ? run_len_q + 3'd1 : 3'd1;
          crc_shift = 1'b1;
        end
        case (state_q)
          S_IDLE: begin
            cnt_d = '0;
            if (!rx_bit) begin
              // clearing alone equals clear-then-shift of the dominant SOF
              state_d = S_ARB;
              crc_clr = 1'b1;
              run_val_d = 1'b0;
              run_len_d = 3'd1;
              id_d = '0;
              ext_d = 1'b0;
              rtr_d = 1'b0;
              dlc_d = '0;
              data_d = '0;
            end
          end
          S_ARB: begin
            if (cnt_q == 6'(ID_BASE)) begin
              rtr_d = rx_bit;
              state_d = S_CTRL;
              cnt_d = '0;
            end else id_d = {id_q[27:0], rx_bit};
          end
          S_CTRL: begin
            // DLC is simply the last four bits shifted through
            dlc_d = {dlc_q[2:0], rx_bit};
            if (ext_q && cnt_q <= 6'(ID_EXT)) id_d = {id_q[27:0], rx_bit};
            if (ext_q && cnt_q == 6'(ID_EXT + 1)) rtr_d = rx_bit;
            if (cnt_q == (ext_q ? 6'(ID_EXT + 3 + DLC_W) : 6'(1 + DLC_W))) begin
              state_d = nb_ctrl == 4'd0 ? S_CRC : S_DATA;
              cnt_d = '0;
            end
            if (cnt_q == '0 && rx_bit) begin
`ifdef CAN_RX_EXT_ID_EN
              ext_d = 1'b1;
`else
              form_err_d = 1'b1;
              state_d = S_ERROR;
              cnt_d = '0;
`endif
            end
          end
          S_DATA: begin
            data_d[6'd63 - cnt_q] = rx_bit;
            if (cnt_q == {3'(nb_data - 4'd1), 3'b111}) begin
              state_d = S_CRC;
              cnt_d = '0;
            end
          end
          S_CRC: begin
            if (cnt_q == 6'(CAN_CRC_BITS - 1)) begin
              crc_err_d = !crc_zero;
              state_d = crc_zero ? S_CRC_DEL : S_ERROR;
              cnt_d = '0;
            end
          end
          S_CRC_DEL: begin
            form_err_d = !rx_bit;
            state_d = rx_bit ? S_ACK : S_ERROR;
            cnt_d = '0;
          end
          S_ACK: begin
            state_d = S_ACK_DEL;
            cnt_d = '0;
          end
          S_ACK_DEL: begin
            form_err_d = !rx_bit;
            state_d = rx_bit ? S_EOF : S_ERROR;
            cnt_d = '0;
          end
          S_EOF: begin
            if (!rx_bit) begin
              form_err_d = 1'b1;
              state_d = S_ERROR;
              cnt_d = '0;
            end else if (cnt_q == 6'(EOF_BITS - 1)) begin
              state_d = S_IDLE;
              cnt_d = '0;
              frame_valid_d = 1'b1;
              frame_id_d = id_q;
              frame_ext_d = ext_q;
              frame_rtr_d = rtr_q;
              frame_dlc_d = dlc_q;
              frame_data_d = data_q;
            end
          end
          S_ERROR: begin
            cnt_d = rx_bit ? cnt_q + 6'd1 : '0;
            if (rx_bit && cnt_q == 6'(IDLE_BITS - 1)) begin
              state_d = S_IDLE;
              cnt_d = '0;
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d = '0;
          end
        endcase
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      id_q <= '0;
      rtr_q <= 1'b0;
      ext_q <= 1'b0;
      dlc_q <= '0;
      data_q <= '0;
      run_val_q <= 1'b0;
      run_len_q <= '0;
      frame_valid_q <= 1'b0;
      crc_err_q <= 1'b0;
      stuff_err_q <= 1'b0;
      form_err_q <= 1'b0;
      frame_id_q <= '0;
      frame_ext_q <= 1'b0;
      frame_rtr_q <= 1'b0;
      frame_dlc_q <= '0;
      frame_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      id_q <= id_d;
      rtr_q <= rtr_d;
      ext_q <= ext_d;
      dlc_q <= dlc_d;
      data_q <= data_d;
      run_val_q <= run_val_d;
      run_len_q <= run_len_d;
      frame_valid_q <= frame_valid_d;
      crc_err_q <= crc_err_d;
      stuff_err_q <= stuff_err_d;
      form_err_q <= form_err_d;
      frame_id_q <= frame_id_d;
      frame_ext_q <= frame_ext_d;
      frame_rtr_q <= frame_rtr_d;
      frame_dlc_q <= frame_dlc_d;
      frame_data_q <= frame_data_d;
    end
  assign busy = state_q != S_IDLE;
  assign frame_valid = frame_valid_q;
  assign crc_err = crc_err_q;
  assign stuff_err = stuff_err_q;
  assign form_err = form_err_q;
  assign frame_id = frame_id_q;
  assign frame_ext = frame_ext_q;
  assign frame_rtr = frame_rtr_q;
  assign frame_dlc = frame_dlc_q;
  assign frame_data = frame_data_q;
endmodule
